seq_detect_scheduler: RTL and testbench

//  Time-shares one bit-serial overlapping pattern matcher (default "101") among NUM_CH byte-wide requesters.

---
 rtl/seq_detect_scheduler_pkg.sv | 15 +
 rtl/seq_detect_scheduler_if.sv | 27 ++
 rtl/seq_window_step.sv | 27 ++
 rtl/seq_detect_scheduler.sv | 169 ++++++++++++++++
 tb/tb_seq_detect_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_scheduler_pkg.sv
// Shared types and constants for the time-shared bit-serial pattern matcher.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  localparam int unsigned DEF_PAT_LEN = 3;
  localparam logic [2:0]  DEF_PAT     = 3'b101;
  localparam int unsigned HIT_CNT_W   = 4;
  localparam int unsigned BYTE_BITS   = 8;

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester / report bundle of seq_detect_scheduler.
// The master drives requests; the slave (the scheduler) answers with ack and hit reports.
interface seq_detect_scheduler_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
);

  logic [NUM_CH-1:0]           req;
  logic [NUM_CH*BYTE_BITS-1:0] data;
  logic [NUM_CH-1:0]           ack;
  logic                        busy;
  logic                        hit_valid;
  logic [$clog2(NUM_CH)-1:0]   hit_ch;
  logic [HIT_CNT_W-1:0]        hit_cnt;

  modport master (
    output req, data,
    input  ack, busy, hit_valid, hit_ch, hit_cnt
  );

  modport slave (
    input  req, data,
    output ack, busy, hit_valid, hit_ch, hit_cnt
  );

endinterface

// File: rtl/seq_window_step.sv
// One bit step of the overlapping pattern window: match test plus next history/fill.
module seq_window_step #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned FILL_W  = 2
) (
  input  logic [PAT_LEN-2:0] hist_i,
  input  logic [FILL_W-1:0]  fill_i,
  input  logic               b_i,
  input  logic [PAT_LEN-1:0] pattern_i,
  output logic               match_o,
  output logic [PAT_LEN-2:0] hist_o,
  output logic [FILL_W-1:0]  fill_o
);

  logic full;

  assign full    = (fill_i == FILL_W'(PAT_LEN - 1));
  assign match_o = full && ({hist_i, b_i} == pattern_i);
  assign fill_o  = full ? fill_i : fill_i + FILL_W'(1);

  if (PAT_LEN == 2) begin : g_hist_one
    assign hist_o = b_i;
  end else begin : g_hist_wide
    assign hist_o = {hist_i[PAT_LEN-3:0], b_i};
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one bit-serial overlapping pattern matcher among
// NUM_CH byte requesters, with per-channel detection context.
// Optional feature macro: SEQ_SCHED_CFG_PATTERN_EN (adds cfg_pattern, sampled at grant).
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int unsigned        NUM_CH  = 4,
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PAT     = PAT_LEN'(DEF_PAT)
) (
  input logic                   clk,
  input logic                   rst,
`ifdef SEQ_SCHED_CFG_PATTERN_EN
  input logic [PAT_LEN-1:0]     cfg_pattern,
`endif
  seq_detect_scheduler_if.slave bus
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned HW     = PAT_LEN - 1;
  localparam int unsigned FILL_W = $clog2(PAT_LEN);
  localparam int unsigned BC_W   = $clog2(BYTE_BITS);

  state_t                 state_q;
  logic [BYTE_BITS-1:0]   byte_q;
  logic [BC_W-1:0]        bit_cnt_q;
  logic [HIT_CNT_W-1:0]   acc_q;
  logic [CH_W-1:0]        grant_q;
  logic [CH_W-1:0]        rr_q;
  logic [HW-1:0]          cur_hist_q;
  logic [FILL_W-1:0]      cur_fill_q;
  logic [PAT_LEN-1:0]     pat_q;
  logic [HW-1:0]          hist_q [NUM_CH];
  logic [FILL_W-1:0]      fill_q [NUM_CH];
  logic [NUM_CH-1:0]      ack_q;
  logic                   busy_q;
  logic                   hit_valid_q;
  logic [CH_W-1:0]        hit_ch_q;
  logic [HIT_CNT_W-1:0]   hit_cnt_q;

  logic                   gnt_found_d;
  logic [CH_W-1:0]        gnt_d;
  logic [CH_W-1:0]        rr_d;
  logic [BYTE_BITS-1:0]   gnt_byte_d;
  logic [NUM_CH-1:0]      ack_d;
  logic [PAT_LEN-1:0]     pat_d;
  logic                   step_match;
  logic [HW-1:0]          step_hist;
  logic [FILL_W-1:0]      step_fill;

`ifdef SEQ_SCHED_CFG_PATTERN_EN
  assign pat_d = cfg_pattern;
`else
  assign pat_d = PAT;
`endif

  // First requesting channel at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_found_d = 1'b0;
    gnt_d       = '0;
    gnt_byte_d  = '0;
    ack_d       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(rr_q) + k) % NUM_CH;
      if (!gnt_found_d && bus.req[idx]) begin
        gnt_found_d = 1'b1;
        gnt_d       = CH_W'(idx);
        gnt_byte_d  = bus.data[idx*BYTE_BITS +: BYTE_BITS];
        ack_d       = '0;
        ack_d[idx]  = 1'b1;
      end
    end
  end

  assign rr_d = (32'(gnt_d) == NUM_CH - 1) ? '0 : gnt_d + CH_W'(1);

  seq_window_step #(
    .PAT_LEN (PAT_LEN),
    .FILL_W  (FILL_W)
  ) u_step (
    .hist_i    (cur_hist_q),
    .fill_i    (cur_fill_q),
    .b_i       (byte_q[BYTE_BITS-1]),
    .pattern_i (pat_q),
    .match_o   (step_match),
    .hist_o    (step_hist),
    .fill_o    (step_fill)
  );

  // Grant / shift / report FSM with registered outputs and per-channel context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      grant_q     <= '0;
      rr_q        <= '0;
      cur_hist_q  <= '0;
      cur_fill_q  <= '0;
      pat_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_ch_q    <= '0;
      hit_cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          hit_valid_q <= 1'b0;
          ack_q       <= '0;
          busy_q      <= 1'b0;
          if (gnt_found_d) begin
            byte_q     <= gnt_byte_d;
            cur_hist_q <= hist_q[gnt_d];
            cur_fill_q <= fill_q[gnt_d];
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            grant_q    <= gnt_d;
            rr_q       <= rr_d;
            pat_q      <= pat_d;
            ack_q      <= ack_d;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          ack_q      <= '0;
          cur_hist_q <= step_hist;
          cur_fill_q <= step_fill;
          byte_q     <= {byte_q[BYTE_BITS-2:0], 1'b0};
          bit_cnt_q  <= bit_cnt_q + BC_W'(1);
          if (step_match) begin
            acc_q <= acc_q + HIT_CNT_W'(1);
          end
          if (bit_cnt_q == BC_W'(BYTE_BITS - 1)) begin
            state_q <= REPORT;
          end
        end
        REPORT: begin
          hist_q[grant_q] <= cur_hist_q;
          fill_q[grant_q] <= cur_fill_q;
          hit_valid_q     <= 1'b1;
          hit_ch_q        <= grant_q;
          hit_cnt_q       <= acc_q;
          // Pending requests keep busy high through the one IDLE cycle before the next grant.
          busy_q          <= |bus.req;
          state_q         <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.hit_ch    = hit_ch_q;
  assign bus.hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler (pattern 3'b101, 4 channels).
module tb_seq_detect_scheduler;
  import seq_detect_pkg::*;

  localparam int unsigned NUM_CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_SCHED_CFG_PATTERN_EN
  logic [2:0] cfg_pattern = 3'b101;
`endif

  seq_detect_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  seq_detect_scheduler #(
    .NUM_CH  (NUM_CH),
    .PAT_LEN (3),
    .PAT     (3'b101)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SEQ_SCHED_CFG_PATTERN_EN
    .cfg_pattern (cfg_pattern),
`endif
    .bus         (bus)
  );

  typedef struct {
    int unsigned ch;
    int unsigned cnt;
  } hit_t;

  hit_t        hit_q[$];
  int unsigned ack_exp_q[$];
  int          checks       = 0;
  int          failures     = 0;
  int          cyc          = 0;
  int          hits_seen    = 0;
  int          last_ack_cyc = -1;
  bit          spacing_chk  = 1'b0;
  bit          busy_watch   = 1'b0;
  logic [3:0]  ack_prev     = '0;
  logic        hv_prev      = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT presents an ack or hit report.
  always @(negedge clk) begin
    hit_t        e;
    int unsigned a;
    if (rst) begin
      ack_prev     = '0;
      hv_prev      = 1'b0;
      last_ack_cyc = -1;
    end else begin
      if (bus.hit_valid === 1'b1) begin
        chk("hit_expected", 32'(hit_q.size() != 0), 1);
        if (hit_q.size() != 0) begin
          e = hit_q.pop_front();
          chk("hit_ch", 32'(bus.hit_ch), e.ch);
          chk("hit_cnt", 32'(bus.hit_cnt), e.cnt);
          chk("hit_latency", cyc - last_ack_cyc, 9);
        end
        hits_seen++;
      end
      if (bus.ack !== '0) begin
        chk("ack_expected", 32'(ack_exp_q.size() != 0), 1);
        if (ack_exp_q.size() != 0) begin
          a = ack_exp_q.pop_front();
          chk("ack_onehot", 32'(bus.ack), 32'(1) << a);
          if (spacing_chk && last_ack_cyc >= 0) chk("ack_spacing", cyc - last_ack_cyc, 10);
        end
        last_ack_cyc = cyc;
      end
      if (ack_prev !== '0) chk("ack_pulse", 32'(bus.ack), 0);
      if (hv_prev === 1'b1) chk("hit_pulse", 32'(bus.hit_valid), 0);
      if (busy_watch) chk("busy_held", 32'(bus.busy), 1);
      ack_prev = bus.ack;
      hv_prev  = bus.hit_valid;
    end
  end

  task automatic wait_ack(input int unsigned ch);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ack[ch] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_seen", 32'(ok), 1);
  endtask

  task automatic wait_hits(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (hits_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hit_seen", 32'(ok), 1);
    #1;
  endtask

  task automatic send(input int unsigned ch, input logic [7:0] b, input int unsigned exp_cnt);
    int target;
    hit_q.push_back('{ch: ch, cnt: exp_cnt});
    ack_exp_q.push_back(ch);
    target = hits_seen + 1;
    bus.data[8*ch +: 8] = b;
    bus.req[ch] = 1'b1;
    wait_ack(ch);
    @(posedge clk);
    #1 bus.req[ch] = 1'b0;
    wait_hits(target);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base;
    bus.req  = '0;
    bus.data = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_hit_valid", 32'(bus.hit_valid), 0);
    chk("rst_hit_ch", 32'(bus.hit_ch), 0);
    chk("rst_hit_cnt", 32'(bus.hit_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic, cross-byte, fresh-context, overlapping and empty bytes.
    send(0, 8'hA5, 2);
    send(0, 8'h40, 1);
    send(1, 8'h40, 0);
    send(2, 8'hAA, 3);
    send(2, 8'h00, 0);

    // All channels requesting from reset: grants 0,1,2,3,0 ten cycles apart.
    @(posedge clk);
    #1 rst = 1'b1;
    bus.data = {8'hDB, 8'h40, 8'hAA, 8'hA5};
    bus.req  = 4'b1111;
    foreach (ack_exp_q[i]) ack_exp_q.delete();
    ack_exp_q.push_back(0); ack_exp_q.push_back(1); ack_exp_q.push_back(2);
    ack_exp_q.push_back(3); ack_exp_q.push_back(0);
    hit_q.push_back('{ch: 0, cnt: 2}); hit_q.push_back('{ch: 1, cnt: 3});
    hit_q.push_back('{ch: 2, cnt: 0}); hit_q.push_back('{ch: 3, cnt: 2});
    hit_q.push_back('{ch: 0, cnt: 2});
    base = hits_seen;
    spacing_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_ack(0);
    busy_watch = 1'b1;
    wait_ack(1);
    wait_ack(2);
    wait_ack(3);
    wait_ack(0);
    busy_watch = 1'b0;
    @(posedge clk);
    #1 bus.req = '0;
    wait_hits(base + 5);
    spacing_chk = 1'b0;

    // Abort a ch1 byte with reset in its 4th shift cycle; ch1 context must be cleared.
    send(1, 8'h01, 0);
    ack_exp_q.push_back(1);
    base = hits_seen;
    bus.data[15:8] = 8'hAA;
    bus.req[1] = 1'b1;
    wait_ack(1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bus.req[1] = 1'b0;
    #1;
    chk("abort_ack", 32'(bus.ack), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_hit_valid", 32'(bus.hit_valid), 0);
    chk("abort_hit_ch", 32'(bus.hit_ch), 0);
    chk("abort_hit_cnt", 32'(bus.hit_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_hit", hits_seen, base);
    send(1, 8'h40, 0);

`ifdef SEQ_SCHED_CFG_PATTERN_EN
    // Runtime pattern, sampled at grant; a mid-byte change must not matter.
    cfg_pattern = 3'b110;
    send(3, 8'hDB, 2);
    hit_q.push_back('{ch: 2, cnt: 2});
    ack_exp_q.push_back(2);
    base = hits_seen;
    bus.data[23:16] = 8'hDB;
    bus.req[2] = 1'b1;
    wait_ack(2);
    cfg_pattern = 3'b000;
    @(posedge clk);
    #1 bus.req[2] = 1'b0;
    wait_hits(base + 1);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(hit_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
